// File: rtl/pattern_matcher_param.sv
// pattern_matcher_param: serial bit-pattern detector with a runtime-loadable pattern and
// don't-care mask, overlapping/non-overlapping detection, an input qualifier and a
// saturating hit counter. The first bit received lines up with bit PAT_W-1 of the pattern.
module pattern_matcher_param #(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = 8'b11101100,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic             datain,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // FILLING: fewer than PAT_W bits collected since the last restart; ARMED: window full
    typedef enum logic [0:0] {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } state_t;

    // Masked compare: only bits with mask=1 must agree with the pattern
    function automatic logic pat_match(input logic [PAT_W-1:0] h,
                                       input logic [PAT_W-1:0] p,
                                       input logic [PAT_W-1:0] m);
        return (((h ^ p) & m) == {PAT_W{1'b0}});
    endfunction

    state_t             state_r, state_next_s, state_adv_s;
    logic [FILL_W-1:0]  fill_r, fill_next_s, fill_adv_s;
    logic [PAT_W-1:0]   hist_r, hist_next_s, hist_shift_s;
    logic [PAT_W-1:0]   pat_r, pat_next_s;
    logic [PAT_W-1:0]   mask_r, mask_next_s;
    logic               overlap_r, overlap_next_s;
    logic               hit_r;
    logic [CNT_W-1:0]   cnt_r, cnt_next_s;
    logic               sat_r, sat_next_s;
    logic               match_s;

    assign hist_shift_s = {hist_r[PAT_W-2:0], datain};

    // Fill/state advance for one accepted bit, before any non-overlap restart
    always_comb begin
        fill_adv_s  = fill_r;
        state_adv_s = state_r;
        case (state_r)
            FILLING: begin
                fill_adv_s = fill_r + FILL_ONE;
                if (fill_r + FILL_ONE == FILL_FULL) begin
                    state_adv_s = ARMED;
                end else begin
                    state_adv_s = FILLING;
                end
            end
            ARMED: begin
                fill_adv_s  = FILL_FULL;
                state_adv_s = ARMED;
            end
            default: begin
                fill_adv_s  = FILL_ZERO;
                state_adv_s = FILLING;
            end
        endcase
    end

    assign match_s = din_valid && !cfg_load && (fill_adv_s == FILL_FULL)
                     && pat_match(hist_shift_s, pat_r, mask_r);

    // Next-state for history, fill, state and configuration (cfg_load beats din_valid)
    always_comb begin
        state_next_s   = state_r;
        fill_next_s    = fill_r;
        hist_next_s    = hist_r;
        pat_next_s     = pat_r;
        mask_next_s    = mask_r;
        overlap_next_s = overlap_r;
        if (cfg_load) begin
            pat_next_s     = cfg_pat;
            mask_next_s    = cfg_mask;
            overlap_next_s = cfg_overlap;
            hist_next_s    = {PAT_W{1'b0}};
            fill_next_s    = FILL_ZERO;
            state_next_s   = FILLING;
        end else if (din_valid) begin
            hist_next_s = hist_shift_s;
            if (match_s && !overlap_r) begin
                fill_next_s  = FILL_ZERO;
                state_next_s = FILLING;
            end else begin
                fill_next_s  = fill_adv_s;
                state_next_s = state_adv_s;
            end
        end else begin
            fill_next_s  = fill_r;
            state_next_s = state_r;
        end
    end

    // Saturating hit counter; a clear wins over a coincident hit
    always_comb begin
        cnt_next_s = cnt_r;
        sat_next_s = sat_r;
        if (cnt_clr) begin
            cnt_next_s = CNT_ZERO;
            sat_next_s = 1'b0;
        end else if (match_s && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
            sat_next_s = (cnt_r == CNT_MAX - CNT_ONE) ? 1'b1 : sat_r;
        end else begin
            cnt_next_s = cnt_r;
            sat_next_s = sat_r;
        end
    end

    // State register: reset restores the default pattern and discards history
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= FILLING;
            fill_r    <= FILL_ZERO;
            hist_r    <= {PAT_W{1'b0}};
            pat_r     <= DEF_PAT;
            mask_r    <= {PAT_W{1'b1}};
            overlap_r <= 1'b1;
            hit_r     <= 1'b0;
            cnt_r     <= CNT_ZERO;
            sat_r     <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            fill_r    <= fill_next_s;
            hist_r    <= hist_next_s;
            pat_r     <= pat_next_s;
            mask_r    <= mask_next_s;
            overlap_r <= overlap_next_s;
            hit_r     <= match_s;
            cnt_r     <= cnt_next_s;
            sat_r     <= sat_next_s;
        end
    end

    assign hit     = hit_r;
    assign hit_cnt = cnt_r;
    assign cnt_sat = sat_r;

endmodule

// File: tb/tb_pattern_matcher_param.sv
// Testbench for pattern_matcher_param: table-driven and hand-written sequences plus
// randomized traffic, all checked against a queue-based reference model.
module tb_pattern_matcher_param;

    localparam int PAT_W = 8;

    logic             clk = 1'b0;
    logic             rst, din_valid, datain, cfg_load, cfg_overlap, cnt_clr;
    logic [PAT_W-1:0] cfg_pat, cfg_mask;
    logic             hit, cnt_sat, hit2, cnt_sat2;
    logic [15:0]      hit_cnt;
    logic [1:0]       hit_cnt2;

    int n_vec = 0;
    int n_bad = 0;
    int hits_seen = 0;

    // reference model state
    bit               q[$];
    logic [PAT_W-1:0] m_pat, m_mask;
    bit               m_ovl, m_hit, m_sat, m_sat2;
    int               m_cnt, m_cnt2;

    always #5 clk = ~clk;

    pattern_matcher_param dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .datain(datain),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .hit(hit), .hit_cnt(hit_cnt), .cnt_sat(cnt_sat)
    );

    pattern_matcher_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .din_valid(din_valid), .datain(datain),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .hit(hit2), .hit_cnt(hit_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: keep the last PAT_W accepted bits since the last restart and compare them.
    task automatic model_update();
        m_hit = 1'b0;
        if (rst) begin
            q.delete();
            m_pat = 8'b11101100; m_mask = 8'hFF; m_ovl = 1'b1;
            m_cnt = 0; m_sat = 1'b0; m_cnt2 = 0; m_sat2 = 1'b0;
        end else begin
            if (cfg_load) begin
                m_pat = cfg_pat; m_mask = cfg_mask; m_ovl = cfg_overlap;
                q.delete();
            end else if (din_valid) begin
                q.push_back(datain);
                if (q.size() > PAT_W) void'(q.pop_front());
                if (q.size() == PAT_W) begin
                    m_hit = 1'b1;
                    for (int i = 0; i < PAT_W; i++)
                        if (m_mask[PAT_W-1-i] && (q[i] != m_pat[PAT_W-1-i])) m_hit = 1'b0;
                end
                if (m_hit && !m_ovl) q.delete();
            end
            if (cnt_clr) begin
                m_cnt = 0; m_sat = 1'b0; m_cnt2 = 0; m_sat2 = 1'b0;
            end else if (m_hit) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt == 65535) m_sat = 1'b1;
                if (m_cnt2 < 3) m_cnt2++;
                if (m_cnt2 == 3) m_sat2 = 1'b1;
            end
        end
    endtask

    // One clock: update the model at the edge, compare all outputs 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        if (hit === 1'b1) hits_seen++;
        check("hit", hit, m_hit);
        check("hit_cnt", hit_cnt, m_cnt);
        check("cnt_sat", cnt_sat, m_sat);
        check("hit2", hit2, m_hit);
        check("hit_cnt2", hit_cnt2, m_cnt2);
        check("cnt_sat2", cnt_sat2, m_sat2);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; din_valid = 1'b0; datain = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic drive(input bit v, input bit d);
        idle_inputs();
        din_valid = v; datain = d;
        cycle();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1; din_valid = 1'b1; datain = 1'b1;
        cycle();
        idle_inputs();
    endtask

    // cfg_load with a valid bit present: the bit must be discarded
    task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m, input bit o);
        idle_inputs();
        cfg_load = 1'b1; cfg_pat = p; cfg_mask = m; cfg_overlap = o;
        din_valid = 1'b1; datain = 1'($urandom_range(0, 1));
        cycle();
        idle_inputs();
    endtask

    // Send n bits MSB first, valid every cycle
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i]);
    endtask

    typedef struct {
        bit v;
        bit d;
        bit exp_hit;
        int exp_cnt;
    } vec_t;

    vec_t t1[9];
    int   h0;
    int   exp2[5];

    initial begin
        t1[0] = '{1'b1, 1'b0, 1'b0, 0};
        t1[1] = '{1'b1, 1'b1, 1'b0, 0};
        t1[2] = '{1'b1, 1'b1, 1'b0, 0};
        t1[3] = '{1'b1, 1'b1, 1'b0, 0};
        t1[4] = '{1'b1, 1'b0, 1'b0, 0};
        t1[5] = '{1'b1, 1'b1, 1'b0, 0};
        t1[6] = '{1'b1, 1'b1, 1'b0, 0};
        t1[7] = '{1'b1, 1'b0, 1'b0, 0};
        t1[8] = '{1'b1, 1'b0, 1'b1, 1};
        exp2 = '{1, 2, 3, 3, 3};

        idle_inputs();
        cfg_pat = 8'h00; cfg_mask = 8'h00; cfg_overlap = 1'b0;
        m_pat = 8'h00; m_mask = 8'h00; m_ovl = 1'b0;
        m_cnt = 0; m_cnt2 = 0; m_sat = 1'b0; m_sat2 = 1'b0;

        // reset state
        do_reset();
        do_reset();
        check("rst_hit", hit, 1'b0);
        check("rst_cnt", hit_cnt, 16'd0);
        check("rst_sat", cnt_sat, 1'b0);

        // test 1: default pattern, table-driven
        for (int i = 0; i < 9; i++) begin
            drive(t1[i].v, t1[i].d);
            check("t1_hit", hit, t1[i].exp_hit);
            check("t1_cnt", hit_cnt, t1[i].exp_cnt);
        end
        drive(1'b0, 1'b0);
        check("t1_hit_drop", hit, 1'b0);

        // test 2: 10101010 overlapping then non-overlapping
        do_reset();
        load(8'b10101010, 8'hFF, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, (i % 2) == 1);
            check("t2_ovl_hit", hit, (i == 8 || i == 10));
        end
        check("t2_ovl_cnt", hit_cnt, 16'd2);
        do_reset();
        load(8'b10101010, 8'hFF, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, (i % 2) == 1);
            check("t2_novl_hit", hit, (i == 8));
        end
        check("t2_novl_cnt", hit_cnt, 16'd1);

        // test 3: default pattern with valid gaps of 1..5 cycles
        do_reset();
        h0 = hits_seen;
        send_bits(32'h0, 1);
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, (8'b11101100 >> i) & 8'h01);
            for (int g = $urandom_range(1, 5); g > 0; g--) begin
                drive(1'b0, 1'($urandom_range(0, 1)));
                check("t3_gap_hit", hit, 1'b0);
            end
        end
        check("t3_hits", hits_seen - h0, 1);
        check("t3_cnt", hit_cnt, 16'd1);

        // test 4: masked pattern 111xxxxx
        do_reset();
        load(8'b11100000, 8'b11100000, 1'b1);
        send_bits({29'd0, 3'b111}, 3);
        send_bits(32'($urandom_range(0, 31)), 5);
        check("t4_hit", hit, 1'b1);
        load(8'b11100000, 8'b11100000, 1'b1);
        h0 = hits_seen;
        send_bits({29'd0, 3'b110}, 3);
        send_bits(32'($urandom_range(0, 31)), 5);
        check("t4_nohit", hits_seen - h0, 0);

        // test 5: 2-bit counter saturation, then clear coincident with a hit
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send_bits(32'hEC, 8);
            check("t5_cnt2", hit_cnt2, exp2[k]);
            check("t5_sat2", cnt_sat2, k >= 2);
        end
        send_bits(32'h76, 7);
        idle_inputs();
        din_valid = 1'b1; datain = 1'b0; cnt_clr = 1'b1;
        cycle();
        check("t5_clr_hit", hit, 1'b1);
        check("t5_clr_cnt", hit_cnt, 16'd0);
        check("t5_clr_sat2", cnt_sat2, 1'b0);

        // test 6: reset and cfg_load in mid-pattern discard history
        do_reset();
        h0 = hits_seen;
        send_bits(32'b111011, 6);
        do_reset();
        send_bits(32'b00, 2);
        check("t6_rst_nohit", hits_seen - h0, 0);
        send_bits(32'b11101, 5);
        load(8'b11101100, 8'hFF, 1'b1);
        send_bits(32'b100, 3);
        check("t6_load_nohit", hits_seen - h0, 0);
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, (8'hEC >> i) & 8'h01);
            check("t6_refill_hit", hit, i == 0);
        end

        // mask all zeros: every valid bit matches once the window is full
        load(8'h00, 8'h00, 1'b1);
        send_bits(32'($urandom), 8);
        check("mask0_hit", hit, 1'b1);
        drive(1'b1, 1'b0);
        check("mask0_hit_next", hit, 1'b1);

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 199);
            if (r < 2) begin
                do_reset();
            end else if (r < 8) begin
                load(8'($urandom), (r < 5) ? 8'($urandom) & 8'($urandom) : 8'($urandom),
                     1'($urandom_range(0, 1)));
            end else begin
                idle_inputs();
                din_valid = ($urandom_range(0, 9) < 8);
                datain = 1'($urandom_range(0, 1));
                cnt_clr = ($urandom_range(0, 99) < 2);
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
